dp_tap_ctrl: RTL and testbench

DP_TAP_CTRL -- requirements
Module: dp_tap_ctrl

---
 rtl/dp_jtag_pkg.sv | 33 +++
 rtl/dp_sync.sv | 22 ++
 rtl/dp_tap_ctrl.sv | 140 ++++++++++++++
 tb/tb_dp_tap_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dp_jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: state encoding,
// instruction codes and the default instruction register width.
package dp_jtag_pkg;

    localparam int IR_W_DEF = 4;

    // The 16 TAP controller states, numbered in their conventional listing order.
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    // Instruction codes; any code not listed here decodes as BYPASS.
    localparam logic [3:0] INSTR_EXTEST = 4'b0000;
    localparam logic [3:0] INSTR_SAMPLE = 4'b0001;
    localparam logic [3:0] INSTR_IDCODE = 4'b0010;
    localparam logic [3:0] INSTR_BYPASS = 4'b1111;

endpackage

// File: rtl/dp_sync.sv
// Two-flop synchronizer for one asynchronous bit into the iclk domain.
module dp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dp_tap_ctrl.sv
// JTAG TAP controller running in the iclk domain. tck/tms/tdi are
// oversampled; all TAP activity happens on the detected tck edges.
// Handshake note: clk_dr and update_dr are single-iclk strobes, valid in
// the cycle they are high; there is no back-pressure on either.
module dp_tap_ctrl
    import dp_jtag_pkg::*;
#(
    parameter int          IR_W   = IR_W_DEF,
    parameter logic [31:0] IDCODE = 32'h1000_0001
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       bsr_sdi,
    input  logic       bsr_sdo,
    output logic       mode,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic [3:0] tap_state
);

    localparam logic [IR_W-1:0] IR_EXTEST = IR_W'(INSTR_EXTEST);
    localparam logic [IR_W-1:0] IR_SAMPLE = IR_W'(INSTR_SAMPLE);
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(INSTR_IDCODE);

    logic tck_s, tms_s, tdi_s, tck_d;
    logic tck_rise, tck_fall;

    tap_state_e state_q, state_d;

    logic [IR_W-1:0] ir_sr, ir_q;
    logic [31:0]     id_sr;
    logic            byp_sr;
    logic            sel_bsr, sel_id;

    dp_sync u_sync_tck (.clk(iclk), .rst(ireset), .d(tck), .q(tck_s));
    dp_sync u_sync_tms (.clk(iclk), .rst(ireset), .d(tms), .q(tms_s));
    dp_sync u_sync_tdi (.clk(iclk), .rst(ireset), .d(tdi), .q(tdi_s));

    // Delayed synchronized tck for edge detection.
    always_ff @(posedge iclk) begin
        if (ireset) tck_d <= 1'b0;
        else        tck_d <= tck_s;
    end

    assign tck_rise = tck_s & ~tck_d;
    assign tck_fall = ~tck_s & tck_d;

    // TAP state register; reset wins over a coincident tck_rise.
    always_ff @(posedge iclk) begin
        if (ireset) state_q <= TEST_LOGIC_RESET;
        else        state_q <= state_d;
    end

    // Standard TAP transition, taken only on tck_rise.
    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TEST_LOGIC_RESET: state_d = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_d = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
                SELECT_DR_SCAN:   state_d = tms_s ? SELECT_IR_SCAN   : CAPTURE_DR;
                CAPTURE_DR:       state_d = tms_s ? EXIT1_DR         : SHIFT_DR;
                SHIFT_DR:         state_d = tms_s ? EXIT1_DR         : SHIFT_DR;
                EXIT1_DR:         state_d = tms_s ? UPDATE_DR        : PAUSE_DR;
                PAUSE_DR:         state_d = tms_s ? EXIT2_DR         : PAUSE_DR;
                EXIT2_DR:         state_d = tms_s ? UPDATE_DR        : SHIFT_DR;
                UPDATE_DR:        state_d = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
                SELECT_IR_SCAN:   state_d = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_d = tms_s ? EXIT1_IR         : SHIFT_IR;
                SHIFT_IR:         state_d = tms_s ? EXIT1_IR         : SHIFT_IR;
                EXIT1_IR:         state_d = tms_s ? UPDATE_IR        : PAUSE_IR;
                PAUSE_IR:         state_d = tms_s ? EXIT2_IR         : PAUSE_IR;
                EXIT2_IR:         state_d = tms_s ? UPDATE_IR        : SHIFT_IR;
                UPDATE_IR:        state_d = tms_s ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
                default:          state_d = TEST_LOGIC_RESET;
            endcase
        end
    end

    // Instruction shift register and active instruction.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            ir_sr <= '0;
            ir_q  <= IR_IDCODE;
        end else begin
            if (tck_rise) begin
                if (state_q == CAPTURE_IR)    ir_sr <= IR_W'(1);
                else if (state_q == SHIFT_IR) ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
            end
            if (state_q == TEST_LOGIC_RESET)             ir_q <= IR_IDCODE;
            else if (tck_fall && state_q == UPDATE_IR)   ir_q <= ir_sr;
        end
    end

    assign sel_bsr = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);
    assign sel_id  = (ir_q == IR_IDCODE);

    // ID and bypass data registers: capture then shift LSB-first on tck_rise.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            id_sr  <= '0;
            byp_sr <= 1'b0;
        end else if (tck_rise) begin
            if (sel_id) begin
                if (state_q == CAPTURE_DR)    id_sr <= IDCODE;
                else if (state_q == SHIFT_DR) id_sr <= {tdi_s, id_sr[31:1]};
            end else if (!sel_bsr) begin
                if (state_q == CAPTURE_DR)    byp_sr <= 1'b0;
                else if (state_q == SHIFT_DR) byp_sr <= tdi_s;
            end
        end
    end

    // tdo changes only on tck_fall so the host samples a stable bit on tck rise.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            tdo <= 1'b0;
        end else if (tck_fall) begin
            case (state_q)
                SHIFT_IR: tdo <= ir_sr[0];
                SHIFT_DR: tdo <= sel_bsr ? bsr_sdo : (sel_id ? id_sr[0] : byp_sr);
                default:  tdo <= 1'b0;
            endcase
        end
    end

    assign mode      = (ir_q == IR_EXTEST);
    assign shift_dr  = (state_q == SHIFT_DR);
    assign clk_dr    = !ireset && tck_rise && sel_bsr &&
                       ((state_q == CAPTURE_DR) || (state_q == SHIFT_DR));
    assign update_dr = !ireset && tck_fall && sel_bsr && (state_q == UPDATE_DR);
    assign bsr_sdi   = tdi_s;
    assign tap_state = state_q;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Bench for dp_tap_ctrl: a JTAG host driver, an 8-bit boundary scan chain
// model on the BSR side, and a tdo scoreboard fed from the host's view of
// what each scan should return.
module tb_dp_tap_ctrl;
    import dp_jtag_pkg::*;

    localparam int          IR_W    = 4;
    localparam logic [31:0] IDC     = 32'h1000_0001;
    localparam int          BSR_LEN = 8;
    localparam int          W       = 1;

    logic       iclk = 1'b0;
    logic       ireset, tck, tms, tdi;
    logic       tdo, bsr_sdi, bsr_sdo, mode, shift_dr, clk_dr, update_dr;
    logic [3:0] tap_state;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_bit;
    event         tdo_evt;

    logic [BSR_LEN-1:0] chain   = '0;
    logic [BSR_LEN-1:0] bsr_cap = '0;
    logic [BSR_LEN-1:0] bsr_out = '0;
    int n_clk_dr = 0;
    int n_upd_dr = 0;

    dp_tap_ctrl #(.IR_W(IR_W), .IDCODE(IDC)) dut (
        .iclk(iclk), .ireset(ireset), .tck(tck), .tms(tms), .tdi(tdi),
        .tdo(tdo), .bsr_sdi(bsr_sdi), .bsr_sdo(bsr_sdo), .mode(mode),
        .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
        .tap_state(tap_state)
    );

    // clock
    always #5 iclk = ~iclk;

    // boundary scan chain model: capture a parallel pattern, then shift toward bit 0
    assign bsr_sdo = chain[0];
    always @(posedge iclk) begin
        if (clk_dr) chain <= shift_dr ? {bsr_sdi, chain[BSR_LEN-1:1]} : bsr_cap;
    end

    // strobe counters and update latch
    always @(negedge iclk) begin
        if (clk_dr) n_clk_dr++;
        if (update_dr) begin
            n_upd_dr++;
            bsr_out = chain;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor: one expected tdo bit per shift strobe
    always @(tdo_evt) begin
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tdo_extra: got %b, expected no bit at %0t", tdo, $time);
        end else begin
            exp_bit = exp_q.pop_front();
            check("tdo", 32'(tdo), 32'(exp_bit));
        end
    end

    // one full tck period; strobe marks a fall that happened in a shift state
    task automatic tck_pulse(input logic t_ms, input logic t_di, input bit strobe);
        tms = t_ms;
        tdi = t_di;
        #40 tck = 1'b1;
        #40 tck = 1'b0;
        #40;
        if (strobe) -> tdo_evt;
    endtask

    // from RUN_TEST_IDLE: load an instruction, return to RUN_TEST_IDLE
    task automatic load_ir(input logic [IR_W-1:0] code);
        for (int i = 0; i < IR_W; i++) exp_q.push_back(W'(i == 0));
        tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < IR_W; i++)
            tck_pulse(i == IR_W - 1, code[i], i != IR_W - 1);
        tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        check("mode_after_ir", 32'(mode), 32'(code == 4'b0000));
        check("state_rti", 32'(tap_state), 32'(RUN_TEST_IDLE));
    endtask

    // from RUN_TEST_IDLE: scan n bits through the DR selected by code
    task automatic run_dr(input logic [3:0] code, input int n, input logic [31:0] data);
        bit is_bsr, is_id;
        int cd, ud;
        is_bsr = (code == 4'b0000) || (code == 4'b0001);
        is_id  = (code == 4'b0010);
        bsr_cap = BSR_LEN'($urandom);
        for (int i = 0; i < n; i++) begin
            if (is_bsr)     exp_q.push_back(W'(bsr_cap[i % BSR_LEN]));
            else if (is_id) exp_q.push_back(W'(IDC[i]));
            else            exp_q.push_back(i == 0 ? 1'b0 : W'(data[i-1]));
        end
        cd = n_clk_dr;
        ud = n_upd_dr;
        tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b1);
        check("shift_dr_high", 32'(shift_dr), 32'd1);
        for (int i = 0; i < n; i++)
            tck_pulse(i == n - 1, data[i], i != n - 1);
        check("shift_dr_low", 32'(shift_dr), 32'd0);
        tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        check("clk_dr_count", 32'(n_clk_dr - cd), is_bsr ? 32'(n + 1) : 32'd0);
        check("update_dr_count", 32'(n_upd_dr - ud), is_bsr ? 32'd1 : 32'd0);
        if (is_bsr && n == BSR_LEN) check("bsr_update_data", 32'(bsr_out), 32'(data[BSR_LEN-1:0]));
    endtask

    // watchdog
    initial begin
        #400us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // main sequence
    initial begin
        logic [3:0] code;
        int ud;
        tck = 1'b0; tms = 1'b0; tdi = 1'b0; ireset = 1'b1;
        repeat (4) @(negedge iclk);
        check("rst_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_ctl", {29'd0, shift_dr, clk_dr, update_dr}, 32'd0);
        ireset = 1'b0;
        @(negedge iclk);

        repeat (5) tck_pulse(1'b1, 1'b0, 1'b0);
        check("tms5_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("tms5_mode", 32'(mode), 32'd0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        check("rti_state", 32'(tap_state), 32'(RUN_TEST_IDLE));

        // default instruction after reset is IDCODE
        run_dr(4'b0010, 32, $urandom);
        load_ir(4'b0010);
        run_dr(4'b0010, 32, $urandom);

        load_ir(4'b1111);
        run_dr(4'b1111, 8, 32'h0000_00A5);

        load_ir(4'b0000);
        run_dr(4'b0000, BSR_LEN, $urandom);
        load_ir(4'b0001);
        run_dr(4'b0001, BSR_LEN, $urandom);
        load_ir(4'b0101);
        run_dr(4'b0101, 8, $urandom);

        for (int k = 0; k < 6; k++) begin
            code = 4'($urandom_range(0, 15));
            load_ir(code);
            if (code == 4'b0000 || code == 4'b0001) run_dr(code, BSR_LEN, $urandom);
            else if (code == 4'b0010)               run_dr(code, $urandom_range(4, 32), $urandom);
            else                                    run_dr(code, $urandom_range(2, 16), $urandom);
        end

        // random walk from EXTEST, then five tms=1 must land in reset with IDCODE active
        load_ir(4'b0000);
        repeat (10) tck_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        repeat (5) tck_pulse(1'b1, 1'b0, 1'b0);
        check("walk_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("walk_mode", 32'(mode), 32'd0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        run_dr(4'b0010, 32, $urandom);

        // reset in the middle of an EXTEST shift
        load_ir(4'b0000);
        tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        repeat (3) tck_pulse(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        ud = n_upd_dr;
        @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        check("midrst_state", 32'(tap_state), 32'(TEST_LOGIC_RESET));
        check("midrst_mode", 32'(mode), 32'd0);
        check("midrst_shift_dr", 32'(shift_dr), 32'd0);
        ireset = 1'b0;
        tck_pulse(1'b0, 1'b0, 1'b0);
        check("midrst_state_rti", 32'(tap_state), 32'(RUN_TEST_IDLE));
        check("midrst_no_update", 32'(n_upd_dr - ud), 32'd0);

        #100;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
